// File: rtl/jtag_dm.sv
// Debug-module responder: decodes DMI requests into a small debug register file and
// drives the core's GPR access, halt and PC-reset inputs, one response per request.
//
// state  | meaning
// IDLE   | ready for a DMI request; register side effects land on the handshake edge
// EXEC   | one-cycle abstract GPR access on the jtag_reg_* port
// RESP   | response held valid and stable until the DTM accepts it
module jtag_dm #(
  parameter int DMI_ADDR_W = 6,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RST_PULSE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dmi_req_valid_i,
  output logic                  dmi_req_ready_o,
  input  logic [1:0]            dmi_req_op_i,
  input  logic [DMI_ADDR_W-1:0] dmi_req_addr_i,
  input  logic [DATA_W-1:0]     dmi_req_data_i,
  output logic                  dmi_resp_valid_o,
  input  logic                  dmi_resp_ready_i,
  output logic [DATA_W-1:0]     dmi_resp_data_o,
  output logic [1:0]            dmi_resp_op_o,
  output logic [REG_ADDR_W-1:0] jtag_reg_addr_o,
  output logic [DATA_W-1:0]     jtag_reg_data_o,
  output logic                  jtag_reg_we_o,
  input  logic [DATA_W-1:0]     jtag_reg_data_i,
  output logic                  jtag_halt_flag_o,
  output logic                  jtag_reset_flag_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [DMI_ADDR_W-1:0] ADDR_DATA0      = DMI_ADDR_W'(6'h04);
  localparam logic [DMI_ADDR_W-1:0] ADDR_DMCONTROL  = DMI_ADDR_W'(6'h10);
  localparam logic [DMI_ADDR_W-1:0] ADDR_DMSTATUS   = DMI_ADDR_W'(6'h11);
  localparam logic [DMI_ADDR_W-1:0] ADDR_ABSTRACTCS = DMI_ADDR_W'(6'h16);
  localparam logic [DMI_ADDR_W-1:0] ADDR_COMMAND    = DMI_ADDR_W'(6'h17);

  localparam int                CNT_W    = $clog2(RST_PULSE + 1);
  localparam logic [CNT_W-1:0]  PULSE_LD = CNT_W'(RST_PULSE);

  state_t                  state, state_nxt;
  logic                    dmactive, haltreq, halted;
  logic [2:0]              cmderr;
  logic [DATA_W-1:0]       data0;
  logic [CNT_W-1:0]        rst_cnt;
  logic                    cmd_write;
  logic [REG_ADDR_W-1:0]   cmd_regno;
  logic [DATA_W-1:0]       resp_data;
  logic [1:0]              resp_op;

  logic req_fire, is_read, is_write;
  logic wr_ctrl, wr_data0, wr_acs, wr_cmd;
  logic cmd_bad, cmd_exec;
  logic [DATA_W-1:0] rd_val;

  assign req_fire = (state == S_IDLE) && dmi_req_valid_i;
  assign is_read  = (dmi_req_op_i == 2'd1);
  assign is_write = (dmi_req_op_i == 2'd2);

  // while dmactive is low only dmcontrol writes take effect
  assign wr_ctrl  = req_fire && is_write && (dmi_req_addr_i == ADDR_DMCONTROL);
  assign wr_data0 = req_fire && is_write && dmactive && (dmi_req_addr_i == ADDR_DATA0);
  assign wr_acs   = req_fire && is_write && dmactive && (dmi_req_addr_i == ADDR_ABSTRACTCS);
  assign wr_cmd   = req_fire && is_write && dmactive && (dmi_req_addr_i == ADDR_COMMAND);

  // only access-register commands to GPRs 0x1000-0x101F are supported
  assign cmd_bad  = (dmi_req_data_i[31:24] != 8'h00) || (dmi_req_data_i[15:5] != 11'h080);
  assign cmd_exec = wr_cmd && (cmderr == 3'd0) && !cmd_bad && halted && dmi_req_data_i[17];

  always_comb begin
    rd_val = '0;
    case (dmi_req_addr_i)
      ADDR_DATA0: rd_val = data0;
      ADDR_DMCONTROL: begin
        rd_val[0]  = dmactive;
        rd_val[31] = haltreq;
      end
      ADDR_DMSTATUS: begin
        rd_val[3:0]   = 4'd2;
        rd_val[7]     = 1'b1;
        rd_val[9:8]   = {2{halted}};
        rd_val[11:10] = {2{~halted}};
      end
      ADDR_ABSTRACTCS: begin
        rd_val[3:0]  = 4'd1;
        rd_val[10:8] = cmderr;
        rd_val[12]   = (state == S_EXEC);
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_fire) state_nxt = cmd_exec ? S_EXEC : S_RESP;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (dmi_resp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dmi_req_ready_o  = 1'b0;
    dmi_resp_valid_o = 1'b0;
    dmi_resp_data_o  = '0;
    dmi_resp_op_o    = 2'd0;
    jtag_reg_addr_o  = '0;
    jtag_reg_data_o  = '0;
    jtag_reg_we_o    = 1'b0;
    case (state)
      S_IDLE: dmi_req_ready_o = 1'b1;
      S_EXEC: begin
        jtag_reg_addr_o = cmd_regno;
        if (cmd_write) begin
          jtag_reg_data_o = data0;
          jtag_reg_we_o   = 1'b1;
        end
      end
      S_RESP: begin
        dmi_resp_valid_o = 1'b1;
        dmi_resp_data_o  = resp_data;
        dmi_resp_op_o    = resp_op;
      end
      default: ;
    endcase
  end

  assign jtag_halt_flag_o  = halted;
  assign jtag_reset_flag_o = (rst_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmactive  <= 1'b0;
      haltreq   <= 1'b0;
      halted    <= 1'b0;
      cmderr    <= 3'd0;
      data0     <= '0;
      rst_cnt   <= '0;
      cmd_write <= 1'b0;
      cmd_regno <= '0;
      resp_data <= '0;
      resp_op   <= 2'd0;
    end else begin
      if (rst_cnt != '0) rst_cnt <= rst_cnt - CNT_W'(1);
      if (req_fire) begin
        resp_data <= is_read ? rd_val : '0;
        resp_op   <= (dmi_req_op_i == 2'd3) ? 2'd2 : 2'd0;
      end
      if (wr_ctrl) begin
        dmactive <= dmi_req_data_i[0];
        // a new ndmreset restarts the pulse from its full length
        if (dmi_req_data_i[1]) rst_cnt <= PULSE_LD;
        if (!dmi_req_data_i[0]) begin
          haltreq <= 1'b0;
          halted  <= 1'b0;
          cmderr  <= 3'd0;
          data0   <= '0;
        end else begin
          haltreq <= dmi_req_data_i[31];
          if (dmi_req_data_i[31])      halted <= 1'b1;
          else if (dmi_req_data_i[30]) halted <= 1'b0;
        end
      end
      if (wr_data0) data0 <= dmi_req_data_i;
      if (wr_acs)   cmderr <= cmderr & ~dmi_req_data_i[10:8];
      if (wr_cmd && (cmderr == 3'd0)) begin
        if (cmd_bad)      cmderr <= 3'd2;
        else if (!halted) cmderr <= 3'd4;
      end
      if (cmd_exec) begin
        cmd_write <= dmi_req_data_i[16];
        cmd_regno <= dmi_req_data_i[REG_ADDR_W-1:0];
      end
      if ((state == S_EXEC) && !cmd_write) data0 <= jtag_reg_data_i;
    end
  end

endmodule
